// File: rtl/alu_exec_pkg.sv
// Shared encodings for the digit-serial ALU execution block.
// Op codes must track the control-path ALU decoder's ALUControl_op values.
package alu_exec_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_digit_serial_exec_if.sv
// Operand/result handshake bundle for alu_digit_serial_exec.
// master = producer of operands / consumer of results; slave = the ALU.
interface alu_digit_serial_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       ALUControl_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, ALUControl_op, src_a, src_b, out_ready,
    input  in_ready, out_valid, alu_result, zero, negative, carry, overflow, busy
  );

  modport slave (
    input  in_valid, ALUControl_op, src_a, src_b, out_ready,
    output in_ready, out_valid, alu_result, zero, negative, carry, overflow, busy
  );
endinterface

// File: rtl/alu_digit_slice.sv
// Combinational DIGIT-bit slice: add (sub arrives pre-inverted with cin=1),
// and, or. Carry out is forced to 0 for the logic ops.
module alu_digit_slice
  import alu_exec_pkg::*;
#(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  alu_op_e          op,
  input  logic             cin,
  output logic [DIGIT-1:0] res,
  output logic             cout
);

  logic [DIGIT:0] sum;

  // Slice result and carry selection by operation
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    res  = '0;
    cout = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB: begin
        res  = sum[DIGIT-1:0];
        cout = sum[DIGIT];
      end
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_digit_serial_exec.sv
// Digit-serial add/sub/and/or execution unit, DIGIT bits per clock.
// Optional macro ALU_FLAGS_EN: when defined, carry/overflow are computed;
// otherwise those outputs are tied to 0 and the overflow logic is absent.
// WIDTH must be a multiple of DIGIT.
module alu_digit_serial_exec
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  alu_digit_serial_exec_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  alu_op_e          op_q, op_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
`ifdef ALU_FLAGS_EN
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
`endif

  logic             in_ready;
  logic [DIGIT-1:0] slice_res;
  logic             slice_cout;

  alu_digit_slice #(.DIGIT(DIGIT)) u_slice (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .op   (op_q),
    .cin  (cy_q),
    .res  (slice_res),
    .cout (slice_cout)
  );

  assign in_ready = (state_q == IDLE) && !reset;

  // Next-state, datapath and flag computation
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    op_d     = op_q;
    cy_d     = cy_q;
    result_d = result_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
`ifdef ALU_FLAGS_EN
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready) begin
          op_d    = alu_op_e'(bus.ALUControl_op);
          a_d     = bus.src_a;
          b_d     = (op_d == ALU_SUB) ? ~bus.src_b : bus.src_b;
          cy_d    = (op_d == ALU_SUB);
          k_d     = '0;
          acc_d   = '0;
`ifdef ALU_FLAGS_EN
          a_msb_d = a_d[WIDTH-1];
          b_msb_d = b_d[WIDTH-1];
`endif
          state_d = CALC;
        end
      end
      CALC: begin
        // Operands drain from the LSB end while results enter at the MSB end,
        // so after N slices acc holds the aligned word.
        acc_d = (acc_q >> DIGIT) | (WIDTH'(slice_res) << (WIDTH - DIGIT));
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        cy_d  = slice_cout;
        k_d   = k_q + CW'(1);
        if (k_q == CW'(N - 1)) begin
          result_d = acc_d;
          zero_d   = (acc_d == '0);
          neg_d    = acc_d[WIDTH-1];
`ifdef ALU_FLAGS_EN
          carry_d  = ((op_q == ALU_ADD) || (op_q == ALU_SUB)) && slice_cout;
          ovf_d    = ((op_q == ALU_ADD) || (op_q == ALU_SUB)) &&
                     (a_msb_q == b_msb_q) && (acc_d[WIDTH-1] != a_msb_q);
`endif
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      op_q        <= ALU_ADD;
      cy_q        <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ALU_FLAGS_EN
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      cy_q        <= cy_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef ALU_FLAGS_EN
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.alu_result = result_q;
  assign bus.zero       = zero_q;
  assign bus.negative   = neg_q;
`ifdef ALU_FLAGS_EN
  assign bus.carry      = carry_q;
  assign bus.overflow   = ovf_q;
`else
  assign bus.carry      = 1'b0;
  assign bus.overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_digit_serial_exec.sv
// Directed, table-driven bench for alu_digit_serial_exec (WIDTH=32, DIGIT=8).
module tb_alu_digit_serial_exec;

  localparam int WIDTH = 32;
  localparam int DIGIT = 8;
  localparam int N     = WIDTH / DIGIT;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[10];

  alu_digit_serial_exec_if #(.WIDTH(WIDTH)) bus();

  alu_digit_serial_exec #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic fl(input logic x);
`ifdef ALU_FLAGS_EN
    return x;
`else
    return 1'b0 & x;
`endif
  endfunction

  task automatic check_outputs(input string tag, input vec_t v);
    chk({tag, ".result"},   bus.alu_result, v.res);
    chk({tag, ".zero"},     32'(bus.zero),     32'(v.z));
    chk({tag, ".negative"}, 32'(bus.negative), 32'(v.n));
    chk({tag, ".carry"},    32'(bus.carry),    32'(fl(v.c)));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(fl(v.v)));
  endtask

  // Accept one op, measure latency to out_valid, leave DUT in DONE.
  task automatic start_and_wait(input string tag, input vec_t v);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid      = 1'b1;
    bus.ALUControl_op = v.op;
    bus.src_a         = v.a;
    bus.src_b         = v.b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    chk({tag, ".latency"}, 32'(lat), 32'(N));
  endtask

  task automatic finish_op(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".in_ready_back"},  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'b00, 32'h00000005, 32'h00000003, 32'h00000008, 0, 0, 0, 0};
    vecs[1] = '{2'b01, 32'h00000005, 32'h00000005, 32'h00000000, 1, 0, 1, 0};
    vecs[2] = '{2'b01, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 0, 1, 0, 0};
    vecs[3] = '{2'b00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0, 1};
    vecs[4] = '{2'b00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 1, 0};
    vecs[5] = '{2'b10, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 1, 0, 0};
    vecs[6] = '{2'b11, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 1, 0, 0};
    vecs[7] = '{2'b01, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 0, 1, 1};
    vecs[8] = '{2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 1, 0, 1, 1};
    vecs[9] = '{2'b00, 32'h000000FF, 32'h00000001, 32'h00000100, 0, 0, 0, 0};

    reset             = 1'b1;
    bus.in_valid      = 1'b0;
    bus.out_ready     = 1'b0;
    bus.ALUControl_op = 2'b00;
    bus.src_a         = '0;
    bus.src_b         = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready_low", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst.in_ready_high", 32'(bus.in_ready),  32'd1);
    chk("rst.busy",          32'(bus.busy),      32'd0);
    chk("rst.out_valid",     32'(bus.out_valid), 32'd0);
    check_outputs("rst", '{2'b00, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0});

    // Table-driven ops
    for (int i = 0; i < 10; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      start_and_wait(tag, vecs[i]);
      check_outputs(tag, vecs[i]);
      finish_op(tag);
    end

    // Backpressure: hold DONE 5 cycles, new op offered and ignored
    start_and_wait("bp", vecs[3]);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.in_valid      = 1'b1;
      bus.ALUControl_op = 2'b11;
      bus.src_a         = 32'h12345678;
      bus.src_b         = 32'h0F0F0F0F;
      @(posedge clk);
      #1;
      chk("bp.out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp.in_ready",  32'(bus.in_ready),  32'd0);
      check_outputs("bp", vecs[3]);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    finish_op("bp");
    chk("bp.result_held", bus.alu_result, 32'h80000000);
    chk("bp.busy_idle",   32'(bus.busy),  32'd0);

    // Reset during CALC digit 2
    @(negedge clk);
    bus.in_valid      = 1'b1;
    bus.ALUControl_op = 2'b11;
    bus.src_a         = 32'hF0F0F0F0;
    bus.src_b         = 32'hFF00FF00;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid.busy_calc", 32'(bus.busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid.out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid.result",    bus.alu_result,     32'h0);
    chk("mid.busy",      32'(bus.busy),      32'd0);
    chk("mid.in_ready",  32'(bus.in_ready),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid.in_ready_after", 32'(bus.in_ready), 32'd1);
    start_and_wait("post", vecs[0]);
    check_outputs("post", vecs[0]);
    finish_op("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
